// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-bundle layout and ALU operation codes
// common to the Controller and the ID/EX pipeline register.
package pipeline_defs;

  localparam int CTRL_W  = 13;
  localparam int ALUOP_W = 4;

  // Control bundle bit positions, MSB first: RegDst .. RegB, then ALUOp[3:0]
  localparam int CTRL_REGDST   = 12;
  localparam int CTRL_REGWRITE = 11;
  localparam int CTRL_ALUSRC   = 10;
  localparam int CTRL_MEMREAD  = 9;
  localparam int CTRL_MEMWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_PCSRC    = 6;
  localparam int CTRL_REGA     = 5;
  localparam int CTRL_REGB     = 4;
  localparam int CTRL_ALUOP_LO = 0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } aluop_e;

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic regdst, input logic regwrite, input logic alusrc,
    input logic memread, input logic memwrite, input logic memtoreg,
    input logic pcsrc, input logic rega, input logic regb,
    input logic [ALUOP_W-1:0] aluop);
    return {regdst, regwrite, alusrc, memread, memwrite, memtoreg,
            pcsrc, rega, regb, aluop};
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector: a load sitting in EX whose destination is a
// source of the instruction currently in ID forces a one-cycle stall.
module hazard_detect (
  input  logic       MemRead_out,
  input  logic       Valid_out,
  input  logic [4:0] Rt_out,
  input  logic [4:0] Rs_in,
  input  logic [4:0] Rt_in,
  output logic       Stall
);

  // Register 0 is hardwired to zero, so a load "into" it never creates a hazard
  assign Stall = MemRead_out && Valid_out && (Rt_out != 5'd0) &&
                 ((Rt_out == Rs_in) || (Rt_out == Rt_in));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squashing
// and saturating stall/flush statistics counters.
module id_ex_stage
  import pipeline_defs::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   RegDst,
  input  logic                   RegWrite,
  input  logic                   ALUSrc,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic                   MemtoReg,
  input  logic                   PCSrc,
  input  logic                   RegA,
  input  logic                   RegB,
  input  logic [3:0]             ALUOp,
  input  logic [DATA_WIDTH-1:0]  ReadData1_in,
  input  logic [DATA_WIDTH-1:0]  ReadData2_in,
  input  logic [DATA_WIDTH-1:0]  SignExt_in,
  input  logic [DATA_WIDTH-1:0]  PCPlus4_in,
  input  logic [4:0]             Rs_in,
  input  logic [4:0]             Rt_in,
  input  logic [4:0]             Rd_in,
  input  logic                   Flush,
  output logic                   RegDst_out,
  output logic                   RegWrite_out,
  output logic                   ALUSrc_out,
  output logic                   MemRead_out,
  output logic                   MemWrite_out,
  output logic                   MemtoReg_out,
  output logic                   PCSrc_out,
  output logic                   RegA_out,
  output logic                   RegB_out,
  output logic [3:0]             ALUOp_out,
  output logic [DATA_WIDTH-1:0]  ReadData1_out,
  output logic [DATA_WIDTH-1:0]  ReadData2_out,
  output logic [DATA_WIDTH-1:0]  SignExt_out,
  output logic [DATA_WIDTH-1:0]  PCPlus4_out,
  output logic [4:0]             Rs_out,
  output logic [4:0]             Rt_out,
  output logic [4:0]             Rd_out,
  output logic                   Valid_out,
  output logic                   Stall,
  output logic [STALL_CNT_W-1:0] StallCount,
  output logic [STALL_CNT_W-1:0] FlushCount
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  logic [CTRL_W-1:0] ctrl_in;
  logic [CTRL_W-1:0] ctrl_q;
  logic              hazard;

  assign ctrl_in = pack_ctrl(RegDst, RegWrite, ALUSrc, MemRead, MemWrite,
                             MemtoReg, PCSrc, RegA, RegB, ALUOp);

  hazard_detect u_hazard (
    .MemRead_out (ctrl_q[CTRL_MEMREAD]),
    .Valid_out   (Valid_out),
    .Rt_out      (Rt_out),
    .Rs_in       (Rs_in),
    .Rt_in       (Rt_in),
    .Stall       (hazard)
  );

  assign Stall = hazard;

  assign RegDst_out   = ctrl_q[CTRL_REGDST];
  assign RegWrite_out = ctrl_q[CTRL_REGWRITE];
  assign ALUSrc_out   = ctrl_q[CTRL_ALUSRC];
  assign MemRead_out  = ctrl_q[CTRL_MEMREAD];
  assign MemWrite_out = ctrl_q[CTRL_MEMWRITE];
  assign MemtoReg_out = ctrl_q[CTRL_MEMTOREG];
  assign PCSrc_out    = ctrl_q[CTRL_PCSRC];
  assign RegA_out     = ctrl_q[CTRL_REGA];
  assign RegB_out     = ctrl_q[CTRL_REGB];
  assign ALUOp_out    = ctrl_q[CTRL_ALUOP_LO +: ALUOP_W];

  // Flush outranks a stall; a stall bubble keeps the old operands so the
  // held ID instruction re-enters with nothing lost.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ctrl_q        <= '0;
      Valid_out     <= 1'b0;
      ReadData1_out <= '0;
      ReadData2_out <= '0;
      SignExt_out   <= '0;
      PCPlus4_out   <= '0;
      Rs_out        <= '0;
      Rt_out        <= '0;
      Rd_out        <= '0;
    end else if (Flush || !hazard) begin
      ctrl_q        <= Flush ? '0 : ctrl_in;
      Valid_out     <= !Flush;
      ReadData1_out <= ReadData1_in;
      ReadData2_out <= ReadData2_in;
      SignExt_out   <= SignExt_in;
      PCPlus4_out   <= PCPlus4_in;
      Rs_out        <= Rs_in;
      Rt_out        <= Rt_in;
      Rd_out        <= Rd_in;
    end else begin
      ctrl_q        <= '0;
      Valid_out     <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (Flush) begin
      if (FlushCount != CNT_MAX) FlushCount <= FlushCount + CNT_ONE;
    end else if (hazard) begin
      if (StallCount != CNT_MAX) StallCount <= StallCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed check of id_ex_stage against a field-level model
// of the pipeline slot, with a narrow counter width to reach saturation.
module tb_id_ex_stage;
  import pipeline_defs::*;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    bit regdst, regwrite, alusrc, memread, memwrite, memtoreg, pcsrc, rega, regb;
    bit [3:0]    aluop;
    bit [DW-1:0] rd1, rd2, se, pc4;
    bit [4:0]    rs, rt, rd;
  } fields_t;

  logic Clk, Rst, Flush;
  logic RegDst_out, RegWrite_out, ALUSrc_out, MemRead_out, MemWrite_out;
  logic MemtoReg_out, PCSrc_out, RegA_out, RegB_out, Valid_out, Stall;
  logic [3:0]    ALUOp_out;
  logic [DW-1:0] ReadData1_out, ReadData2_out, SignExt_out, PCPlus4_out;
  logic [4:0]    Rs_out, Rt_out, Rd_out;
  logic [CW-1:0] StallCount, FlushCount;

  fields_t cur, m;
  bit      mValid;
  int      mSc, mFc;
  int      checks = 0;
  int      errors = 0;

  id_ex_stage #(.DATA_WIDTH(DW), .STALL_CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .RegDst(cur.regdst), .RegWrite(cur.regwrite), .ALUSrc(cur.alusrc),
    .MemRead(cur.memread), .MemWrite(cur.memwrite), .MemtoReg(cur.memtoreg),
    .PCSrc(cur.pcsrc), .RegA(cur.rega), .RegB(cur.regb), .ALUOp(cur.aluop),
    .ReadData1_in(cur.rd1), .ReadData2_in(cur.rd2), .SignExt_in(cur.se),
    .PCPlus4_in(cur.pc4), .Rs_in(cur.rs), .Rt_in(cur.rt), .Rd_in(cur.rd),
    .Flush(Flush),
    .RegDst_out(RegDst_out), .RegWrite_out(RegWrite_out), .ALUSrc_out(ALUSrc_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .MemtoReg_out(MemtoReg_out), .PCSrc_out(PCSrc_out), .RegA_out(RegA_out),
    .RegB_out(RegB_out), .ALUOp_out(ALUOp_out),
    .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out),
    .SignExt_out(SignExt_out), .PCPlus4_out(PCPlus4_out),
    .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out),
    .Valid_out(Valid_out), .Stall(Stall),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic bit modelHazard();
    return mValid && m.memread && (m.rt != 5'd0) &&
           ((m.rt == cur.rs) || (m.rt == cur.rt));
  endfunction

  function automatic fields_t clearCtrl(input fields_t f);
    fields_t g = f;
    {g.regdst, g.regwrite, g.alusrc, g.memread, g.memwrite,
     g.memtoreg, g.pcsrc, g.rega, g.regb} = '0;
    g.aluop = '0;
    return g;
  endfunction

  function automatic fields_t randFields();
    fields_t f;
    {f.regdst, f.regwrite, f.alusrc, f.memread, f.memwrite,
     f.memtoreg, f.pcsrc, f.rega, f.regb} = 9'($urandom);
    f.aluop = 4'($urandom);
    f.rd1 = $urandom;
    f.rd2 = $urandom;
    f.se  = $urandom;
    f.pc4 = $urandom;
    f.rs  = 5'($urandom_range(0, 3));
    f.rt  = 5'($urandom_range(0, 3));
    f.rd  = 5'($urandom);
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkSlot(input string tag);
    checkOutput({tag, "_ctrl"},
      128'({RegDst_out, RegWrite_out, ALUSrc_out, MemRead_out, MemWrite_out,
            MemtoReg_out, PCSrc_out, RegA_out, RegB_out, ALUOp_out}),
      128'({m.regdst, m.regwrite, m.alusrc, m.memread, m.memwrite,
            m.memtoreg, m.pcsrc, m.rega, m.regb, m.aluop}));
    checkOutput({tag, "_valid"}, 128'(Valid_out), 128'(mValid));
    checkOutput({tag, "_data"},
      {ReadData1_out, ReadData2_out, SignExt_out, PCPlus4_out},
      {m.rd1, m.rd2, m.se, m.pc4});
    checkOutput({tag, "_regs"}, 128'({Rs_out, Rt_out, Rd_out}),
                128'({m.rs, m.rt, m.rd}));
    checkOutput({tag, "_stallcnt"}, 128'(StallCount), 128'(mSc));
    checkOutput({tag, "_flushcnt"}, 128'(FlushCount), 128'(mFc));
  endtask

  // One instruction slot: drive on the falling edge, check Stall, then the slot
  task automatic applyStimulus(input string tag, input fields_t f, input bit fl);
    bit hz;
    @(negedge Clk);
    cur = f;
    Flush = fl;
    #1;
    hz = modelHazard();
    checkOutput({tag, "_stall"}, 128'(Stall), 128'(hz));
    @(posedge Clk);
    if (fl) begin
      m = clearCtrl(cur);
      mValid = 1'b0;
      if (mFc < CMAX) mFc++;
    end else if (hz) begin
      m = clearCtrl(m);
      mValid = 1'b0;
      if (mSc < CMAX) mSc++;
    end else begin
      m = cur;
      mValid = 1'b1;
    end
    #1;
    checkSlot(tag);
  endtask

  task automatic modelReset();
    m = '0;
    mValid = 1'b0;
    mSc = 0;
    mFc = 0;
  endtask

  initial begin
    fields_t f;
    Rst = 1'b1;
    Flush = 1'b0;
    cur = '0;
    modelReset();
    #3;
    checkSlot("reset");
    checkOutput("reset_stall", 128'(Stall), 128'(0));
    @(negedge Clk);
    Rst = 1'b0;

    f = '0; f.regwrite = 1'b1; f.aluop = ALU_ADD; f.rd1 = 32'h0000_0005;
    applyStimulus("basic", f, 1'b0);
    checkOutput("basic_valid_one", 128'(Valid_out), 128'(1));

    // Flush arriving together with a load-use hazard counts only as a flush
    f = '0; f.memread = 1'b1; f.rt = 5'd8;
    applyStimulus("fl_load", f, 1'b0);
    f = '0; f.rs = 5'd8; f.regwrite = 1'b1;
    applyStimulus("fl_hazard", f, 1'b1);
    checkOutput("fl_flushcnt_one", 128'(FlushCount), 128'(1));
    checkOutput("fl_stallcnt_zero", 128'(StallCount), 128'(0));

    f = '0; f.memread = 1'b1; f.rt = 5'd8; f.rd1 = 32'hdead_beef;
    applyStimulus("lu_load", f, 1'b0);
    f = '0; f.rs = 5'd8; f.regwrite = 1'b1; f.rd1 = 32'h1234_5678;
    applyStimulus("lu_bubble", f, 1'b0);
    checkOutput("lu_stallcnt_one", 128'(StallCount), 128'(1));
    applyStimulus("lu_replay", f, 1'b0);
    checkOutput("lu_replay_valid", 128'(Valid_out), 128'(1));

    f = '0; f.memread = 1'b1; f.rt = 5'd0;
    applyStimulus("r0_load", f, 1'b0);
    f = '0; f.rs = 5'd0; f.rt = 5'd0;
    applyStimulus("r0_use", f, 1'b0);
    checkOutput("r0_stallcnt", 128'(StallCount), 128'(1));

    for (int i = 0; i < 16; i++) begin
      f = randFields(); f.memread = 1'b1; f.rt = 5'd8;
      applyStimulus("sat_load", f, 1'b0);
      f = randFields(); f.rs = 5'd8; f.rt = 5'd8;
      applyStimulus("sat_bubble", f, 1'b0);
    end
    checkOutput("sat_stallcnt_max", 128'(StallCount), 128'(CMAX));

    // Reset asserted between edges while a bubble is pending
    f = randFields(); f.memread = 1'b1; f.rt = 5'd9;
    applyStimulus("rs_load", f, 1'b0);
    @(negedge Clk);
    f = randFields(); f.rs = 5'd9;
    cur = f;
    #1;
    checkOutput("rs_pending_stall", 128'(Stall), 128'(1));
    #1;
    Rst = 1'b1;
    #1;
    modelReset();
    checkSlot("rs_async");
    checkOutput("rs_async_stall", 128'(Stall), 128'(0));
    #1;
    Rst = 1'b0;
    @(posedge Clk);
    m = cur;
    mValid = 1'b1;
    #1;
    checkSlot("rs_release");

    for (int i = 0; i < 150; i++) begin
      f = randFields();
      applyStimulus("rand", f, ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
